// File: rtl/c3lib_cg_seq_ctrl_if.sv
// Handshake/status bundle between a power/clock manager (master) and the
// gating-cell sequencer (slave). force_on exists only with C3LIB_CG_SEQ_FORCE_EN.
interface c3lib_cg_seq_ctrl_if #(
    parameter int NUM_LANES = 4
);
    logic                 en_req;
`ifdef C3LIB_CG_SEQ_FORCE_EN
    logic                 force_on;
`endif
    logic [NUM_LANES-1:0] gate_en;
    logic                 all_on;
    logic                 all_off;
    logic                 busy;

    modport master (
        output en_req,
`ifdef C3LIB_CG_SEQ_FORCE_EN
        output force_on,
`endif
        input  gate_en,
        input  all_on,
        input  all_off,
        input  busy
    );

    modport slave (
        input  en_req,
`ifdef C3LIB_CG_SEQ_FORCE_EN
        input  force_on,
`endif
        output gate_en,
        output all_on,
        output all_off,
        output busy
    );
endinterface

// File: rtl/c3lib_cg_seq_ctrl.sv
// Staggered enable sequencer for a bank of c3lib AND gating cells.
// Optional override via `define C3LIB_CG_SEQ_FORCE_EN (adds bus.force_on).
module c3lib_cg_seq_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int STAGGER_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    c3lib_cg_seq_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);
    localparam int TMR_W = $clog2(STAGGER_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_RLD = TMR_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_LANES);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     lane_cnt_q, lane_cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [NUM_LANES-1:0] gate_en_q, gate_en_d;
    logic                 all_on_q, all_on_d;
    logic                 all_off_q, all_off_d;
    logic                 busy_q, busy_d;
`ifdef C3LIB_CG_SEQ_FORCE_EN
    logic                 force_q, force_d;
`endif

    // Lane i is enabled while i < n; lanes fill from bit 0 upward.
    function automatic logic [NUM_LANES-1:0] therm(input logic [CNT_W-1:0] n);
        logic [NUM_LANES-1:0] t;
        t = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            t[i] = (CNT_W'(i) < n);
        end
        return t;
    endfunction

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        tmr_d      = tmr_q;

        unique case (state_q)
            OFF: begin
                if (bus.en_req) begin
                    state_d    = RAMP_UP;
                    lane_cnt_d = CNT_W'(1);
                    tmr_d      = TMR_RLD;
                end
            end
            RAMP_UP: begin
                // Reversal drops the most recently enabled lane first.
                if (!bus.en_req) begin
                    state_d    = RAMP_DOWN;
                    lane_cnt_d = lane_cnt_q - 1'b1;
                    tmr_d      = TMR_RLD;
                end else if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (lane_cnt_q < CNT_MAX) begin
                    lane_cnt_d = lane_cnt_q + 1'b1;
                    tmr_d      = TMR_RLD;
                end else begin
                    state_d = ON;
                end
            end
            ON: begin
                if (!bus.en_req) begin
                    state_d    = RAMP_DOWN;
                    lane_cnt_d = CNT_MAX - 1'b1;
                    tmr_d      = TMR_RLD;
                end
            end
            RAMP_DOWN: begin
                // lane_cnt is at most NUM_LANES-1 here, so +1 cannot overflow.
                if (bus.en_req) begin
                    state_d    = RAMP_UP;
                    lane_cnt_d = lane_cnt_q + 1'b1;
                    tmr_d      = TMR_RLD;
                end else if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (lane_cnt_q != '0) begin
                    lane_cnt_d = lane_cnt_q - 1'b1;
                    tmr_d      = TMR_RLD;
                end else begin
                    state_d = OFF;
                end
            end
            default: begin
                state_d    = OFF;
                lane_cnt_d = '0;
                tmr_d      = '0;
            end
        endcase

`ifdef C3LIB_CG_SEQ_FORCE_EN
        // Freeze while forced and for the release edge, so gate_en first
        // returns to the frozen lane count before the ramp continues.
        force_d = bus.force_on;
        if (bus.force_on || force_q) begin
            state_d    = state_q;
            lane_cnt_d = lane_cnt_q;
            tmr_d      = tmr_q;
        end
        gate_en_d = bus.force_on ? '1 : therm(lane_cnt_d);
`else
        gate_en_d = therm(lane_cnt_d);
`endif

        all_on_d  = (state_d == ON);
        all_off_d = (state_d == OFF);
        busy_d    = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            lane_cnt_q <= '0;
            tmr_q      <= '0;
            gate_en_q  <= '0;
            all_on_q   <= 1'b0;
            all_off_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            tmr_q      <= tmr_d;
            gate_en_q  <= gate_en_d;
            all_on_q   <= all_on_d;
            all_off_q  <= all_off_d;
            busy_q     <= busy_d;
        end
    end

`ifdef C3LIB_CG_SEQ_FORCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_q <= 1'b0;
        end else begin
            force_q <= force_d;
        end
    end
`endif

    assign bus.gate_en = gate_en_q;
    assign bus.all_on  = all_on_q;
    assign bus.all_off = all_off_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_c3lib_cg_seq_ctrl.sv
// Directed bench: expected per-cycle outputs are queued as stimulus is driven
// and popped against two sequencer configurations (4x2 and 1x1).
module tb_c3lib_cg_seq_ctrl;

    localparam int NA = 4;
    localparam int SA = 2;

    logic clk;
    logic rst_n;

    c3lib_cg_seq_ctrl_if #(.NUM_LANES(NA)) ifa ();
    c3lib_cg_seq_ctrl_if #(.NUM_LANES(1))  ifb ();

    c3lib_cg_seq_ctrl #(.NUM_LANES(NA), .STAGGER_CYC(SA)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    c3lib_cg_seq_ctrl #(.NUM_LANES(1), .STAGGER_CYC(1)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] v;    // {gate_en[3:0], all_on, all_off, busy}
        string      tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [3:0] therm4(input int n);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) t[i] = (i < n);
        return t;
    endfunction

    task automatic pa(input logic [3:0] g, input logic on, input logic off,
                      input logic bsy, input string tag);
        exp_t e;
        e.v = {g, on, off, bsy};
        e.tag = tag;
        qa.push_back(e);
    endtask

    task automatic pb(input logic g, input logic on, input logic off,
                      input logic bsy, input string tag);
        exp_t e;
        e.v = {3'b000, g, on, off, bsy};
        e.tag = tag;
        qb.push_back(e);
    endtask

    // Expected ramp-up from the edge that first samples en_req=1 out of OFF
    // (or at lane_cnt=0 in RAMP_DOWN): lane i rises at i*SA, all_on at NA*SA.
    task automatic push_ramp_up(input string tag);
        for (int k = 0; k <= NA * SA; k++) begin
            if (k < NA * SA) pa(therm4(k / SA + 1), 1'b0, 1'b0, 1'b1, tag);
            else             pa(4'hF, 1'b1, 1'b0, 1'b0, tag);
        end
    endtask

    task automatic push_ramp_down(input string tag);
        for (int k = 0; k <= NA * SA; k++) begin
            if (k < NA * SA) pa(therm4(NA - 1 - k / SA), 1'b0, 1'b0, 1'b1, tag);
            else             pa(4'h0, 1'b0, 1'b1, 1'b0, tag);
        end
    endtask

    task automatic check_now();
        exp_t e;
        logic [6:0] obs;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            obs = {ifa.gate_en, ifa.all_on, ifa.all_off, ifa.busy};
            checks++;
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s dutA t=%0t got=%b want=%b", e.tag, $time, obs, e.v);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            obs = {3'b000, ifb.gate_en, ifb.all_on, ifb.all_off, ifb.busy};
            checks++;
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s dutB t=%0t got=%b want=%b", e.tag, $time, obs, e.v);
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        ifa.en_req = 1'b0;
        ifb.en_req = 1'b0;
`ifdef C3LIB_CG_SEQ_FORCE_EN
        ifa.force_on = 1'b0;
        ifb.force_on = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        pa(4'h0, 1'b0, 1'b1, 1'b0, "reset");
        pb(1'b0, 1'b0, 1'b1, 1'b0, "reset");
        check_now();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Idle in OFF with en_req low.
        repeat (2) begin
            pa(4'h0, 1'b0, 1'b1, 1'b0, "idle_off");
            pb(1'b0, 1'b0, 1'b1, 1'b0, "idle_off");
        end
        run_cycles(2);

        // Single lane, one-cycle stagger.
        ifb.en_req = 1'b1;
        pb(1'b1, 1'b0, 1'b0, 1'b1, "b_up");
        pb(1'b1, 1'b1, 1'b0, 1'b0, "b_on");
        pb(1'b1, 1'b1, 1'b0, 1'b0, "b_on_hold");
        run_cycles(3);
        ifb.en_req = 1'b0;
        pb(1'b0, 1'b0, 1'b0, 1'b1, "b_down");
        pb(1'b0, 1'b0, 1'b1, 1'b0, "b_off");
        run_cycles(2);

        // Full ramp up, hold ON, full ramp down.
        ifa.en_req = 1'b1;
        push_ramp_up("ramp_up");
        pa(4'hF, 1'b1, 1'b0, 1'b0, "on_hold");
        pa(4'hF, 1'b1, 1'b0, 1'b0, "on_hold");
        run_cycles(NA * SA + 3);
        ifa.en_req = 1'b0;
        push_ramp_down("ramp_down");
        run_cycles(NA * SA + 1);

        // Reversal mid ramp-up at gate_en=0011.
        ifa.en_req = 1'b1;
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev_up");
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev_up");
        pa(4'h3, 1'b0, 1'b0, 1'b1, "rev_up");
        run_cycles(3);
        ifa.en_req = 1'b0;
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev_down");
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev_down");
        pa(4'h0, 1'b0, 1'b0, 1'b1, "rev_down");
        pa(4'h0, 1'b0, 1'b0, 1'b1, "rev_down");
        pa(4'h0, 1'b0, 1'b1, 1'b0, "rev_off");
        run_cycles(5);

        // Same reversal, then re-request at lane_cnt=0 while tmr is still running.
        ifa.en_req = 1'b1;
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev2_up");
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev2_up");
        pa(4'h3, 1'b0, 1'b0, 1'b1, "rev2_up");
        run_cycles(3);
        ifa.en_req = 1'b0;
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev2_down");
        pa(4'h1, 1'b0, 1'b0, 1'b1, "rev2_down");
        pa(4'h0, 1'b0, 1'b0, 1'b1, "rev2_down");
        run_cycles(3);
        ifa.en_req = 1'b1;
        push_ramp_up("rev_at_zero");
        run_cycles(NA * SA + 1);
        ifa.en_req = 1'b0;
        push_ramp_down("ramp_down2");
        run_cycles(NA * SA + 1);

        // Reset mid ramp-up with en_req held high.
        ifa.en_req = 1'b1;
        for (int k = 0; k < 6; k++) pa(therm4(k / SA + 1), 1'b0, 1'b0, 1'b1, "pre_rst");
        run_cycles(6);
        rst_n = 1'b0;
        #1;
        pa(4'h0, 1'b0, 1'b1, 1'b0, "async_rst");
        check_now();
        @(negedge clk) rst_n = 1'b1;
        push_ramp_up("restart");
        run_cycles(NA * SA + 1);

        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $error("FAIL queue_drain left a=%0d b=%0d want 0", qa.size(), qb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
